// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and state encoding for the RV32M multiply/divide unit
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// cond_negate: two's-complement negate when neg is set, pass-through otherwise
module cond_negate #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);

    assign out = neg ? -in : in;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, shift-add multiply and restoring divide
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    state_t          state, state_nx;
    logic [2:0]      op;
    logic            s1, s2, dz;
    logic [XLEN-1:0] hi, lo, m;
    logic [CW-1:0]   cnt;

    logic            sgn1, sgn2, neg1, neg2, div0, ovf, early, accept, ge;
    logic [XLEN-1:0] a_abs, b_abs, hi_it, lo_it, quo, rem, res_nx;
    logic [XLEN:0]   mul_sum, shifted, diff;
    logic [2*XLEN-1:0] prod;

    // MULHSU treats rs2 as unsigned, so only rs1 gets a magnitude there
    assign sgn1   = funct3 == F3_MULH || funct3 == F3_MULHSU || funct3 == F3_DIV || funct3 == F3_REM;
    assign sgn2   = funct3 == F3_MULH || funct3 == F3_DIV || funct3 == F3_REM;
    assign neg1   = sgn1 & data1[XLEN-1];
    assign neg2   = sgn2 & data2[XLEN-1];
    assign div0   = funct3[2] && data2 == '0;
    assign ovf    = (funct3 == F3_DIV || funct3 == F3_REM) && data1 == {1'b1, {(XLEN-1){1'b0}}} && &data2;
    assign early  = EARLY_OUT && (div0 || ovf);
    assign accept = state == ST_IDLE && start && !flush;
    assign busy   = state != ST_IDLE;

    cond_negate #(.W(XLEN)) u_abs1 (.neg(neg1), .in(data1), .out(a_abs));
    cond_negate #(.W(XLEN)) u_abs2 (.neg(neg2), .in(data2), .out(b_abs));

    // one iteration step: mul adds the multiplicand then shifts the product right,
    // div shifts the remainder left and keeps the trial subtraction when non-negative
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    assign shifted = {hi, lo[XLEN-1]};
    assign diff    = shifted - {1'b0, m};
    assign ge      = !diff[XLEN];
    assign hi_it   = op[2] ? (ge ? diff[XLEN-1:0] : shifted[XLEN-1:0]) : mul_sum[XLEN:1];
    assign lo_it   = op[2] ? {lo[XLEN-2:0], ge} : {mul_sum[0], lo[XLEN-1:1]};

    // sign fix: full-width product negate, quotient sign s1^s2, remainder follows dividend
    cond_negate #(.W(2*XLEN)) u_prod (.neg(s1 ^ s2), .in({hi, lo}), .out(prod));
    cond_negate #(.W(XLEN))   u_quo  (.neg(s1 ^ s2), .in(lo), .out(quo));
    cond_negate #(.W(XLEN))   u_rem  (.neg(s1), .in(hi), .out(rem));

    assign res_nx = op == F3_MUL ? prod[XLEN-1:0] :
                    !op[2]       ? prod[2*XLEN-1:XLEN] :
                    !op[1]       ? (dz ? '1 : quo) : rem;

    // next-state: flush always wins, special cases may skip straight to FIN
    always_comb begin
        state_nx = state;
        state_nx = flush              ? ST_IDLE :
                   state == ST_IDLE   ? (start ? (early ? ST_FIN : ST_CALC) : ST_IDLE) :
                   state == ST_CALC   ? (cnt == '0 ? ST_FIN : ST_CALC) : ST_IDLE;
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // operand latch, iteration datapath and result/done registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op     <= '0;
            s1     <= 1'b0;
            s2     <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            m      <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= state == ST_FIN && !flush;
            if (state == ST_FIN && !flush) result <= res_nx;
            if (accept) begin
                op  <= funct3;
                s1  <= neg1;
                s2  <= neg2;
                dz  <= div0;
                cnt <= CW'(XLEN - 1);
                m   <= funct3[2] ? b_abs : a_abs;
                lo  <= funct3[2] ? a_abs : b_abs;
                hi  <= (early && div0) ? a_abs : '0;
            end else if (state == ST_CALC) begin
                hi  <= hi_it;
                lo  <= lo_it;
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule
